core_sequencer: RTL and testbench
=================================

# core_sequencer

Multi-cycle control FSM for the floppycomp RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback. It owns the program counter and instruction register, handshakes with the instruction and data memory ports, and gates register-file writes. It sits between the memory interfaces and the combinational decode/ALU datapath, consuming decode flags computed from its own `instr` output.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `TRAP_VEC`, 32'h0000_0100, PC loaded on illegal-instruction trap (used only with `ILLEGAL_TRAP_EN`).

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  32  fetch address; equals `pc`.
- `imem_ready`  in  1  fetch completes this cycle; `imem_rdata` is valid.
- `imem_rdata`  in  32  fetched instruction word.
- `instr`  out  32  instruction register; feeds decode.
- `dec_is_load`, `dec_is_store`, `dec_writes_rd`, `dec_illegal`  in  1 each  decode flags for `instr`.
- `branch_taken`  in  1  execute-stage redirect.
- `branch_target`  in  32  execute-stage redirect address.
- `dmem_req`  out  1  data access request.
- `dmem_we`  out  1  data access is a store.
- `dmem_ready`  in  1  data access completes this cycle.
- `pc`  out  32  current instruction address.
- `rf_we`  out  1  register-file write enable.
- `retire`  out  1  one-cycle pulse per completed instruction.
- `trap`  out  1  one-cycle pulse on illegal instruction. Present only with `ILLEGAL_TRAP_EN`.

## Operation
- States: `FETCH`, `DECODE`, `EXECUTE`, `MEM`, `WB`, plus `TRAP` with the macro.
- `FETCH`:
  - `imem_req`=1.
  - On `imem_ready`: `instr` <= `imem_rdata`, go to `DECODE`. Otherwise hold, with no timeout.
- `DECODE`: one cycle, always go to `EXECUTE`. Decode flags are sampled only from this state onward.
- `EXECUTE`:
  - Latch `branch_taken` and `branch_target`.
  - Go to `MEM` if `dec_is_load|dec_is_store`, else go to `WB`.
  - Illegal handling is described under Configuration.
- `MEM`:
  - `dmem_req`=1 and `dmem_we`=`dec_is_store`.
  - Hold until `dmem_ready`, then go to `WB`.
- `WB`:
  - `rf_we`=`dec_writes_rd`; `retire`=1.
  - `pc` <= latched taken ? {target[31:2],2'b00} : `pc`+4, with modulo 2^32 wrap.
  - Go to `FETCH`.
- All outputs other than `pc`/`instr`/`imem_addr` are Moore, decoded from state, and are 0 outside their named state.
- `imem_rdata` is ignored unless `imem_ready` is high in `FETCH`. `dmem_ready` is ignored outside `MEM`.

## Timing
- Reset values: state=`FETCH`, `pc`=`RESET_PC`, `instr`=32'h0000_0013 (NOP), branch latch=0.
- Because `FETCH` is the reset state, `imem_req`=1 in the first cycle after `rst` deasserts.
- Latency with zero-wait memory:
  - ALU/branch instruction: 4 cycles, fetch to retire.
  - Load/store: 5 cycles.
  - Each wait cycle on `imem_ready` or `dmem_ready` adds 1.
- `rst` asserted in any state overrides all transitions. The in-flight instruction is dropped: no `retire`, no `rf_we`, no `pc` update other than to `RESET_PC`.
- `pc` and `instr` change only on the `WB`→`FETCH` edge and the `FETCH`→`DECODE` edge respectively, plus the trap path.

## Configuration
- `ILLEGAL_TRAP_EN` defined:
  - `EXECUTE` with `dec_illegal`=1 goes to `TRAP`.
  - `TRAP` lasts one cycle: `trap`=1, `pc` <= `TRAP_VEC`, then go to `FETCH`.
  - No `retire` and no `rf_we` for the illegal instruction.
- `ILLEGAL_TRAP_EN` undefined:
  - `dec_illegal` is ignored.
  - The instruction proceeds to `WB` as a NOP: `rf_we` forced to 0, `retire`=1, `pc`+4.
  - The `trap` port and `TRAP` state are absent.

## Structure
- Shared package (alongside `word`, `control_signals_t`, `OPCODE_*`):
  - `core_state_t` enum.
  - `NOP_INSTR` constant.
  - Default `RESET_PC`/`TRAP_VEC` values.
- No sub-module. A single FSM with PC, IR and branch-latch registers. Decode stays a separate, externally instantiated block.

## Test plan
- Reset, then `imem_ready`=1 each cycle fetching ADDI x1,x0,5 -> `imem_addr`=0; `rf_we` and `retire` high in cycle 4; next `imem_addr`=4.
- LW with `dmem_ready` delayed 3 cycles -> `dmem_req` high 4 cycles with `dmem_we`=0; `retire` in cycle 8; `pc`=4.
- SW -> `dmem_we`=1 in `MEM`; `rf_we`=0 in `WB`.
- Taken branch with `pc`=32'h10, `branch_target`=32'h42 -> next `imem_addr`=32'h40. Separately, non-branch with `pc`=32'hFFFF_FFFC -> next `pc`=0.
- `rst` pulsed during `MEM` wait -> no `retire`; `imem_addr`=`RESET_PC` the cycle after release.
- Illegal word 32'h0000_0000:
  - with the macro: `trap` pulse, next `imem_addr`=32'h100, no `retire`;
  - without the macro: `retire`=1, `rf_we`=0, `pc`+4.

Source files
------------

// File: rtl/core_sequencer_pkg.sv
// Shared types and constants for the floppycomp RV32I core.
// ILLEGAL_TRAP_EN adds the TRAP state to core_state_t.
package core_sequencer_pkg;

  typedef logic [31:0] word;

  typedef struct packed {
    logic is_load;
    logic is_store;
    logic writes_rd;
    logic illegal;
  } control_signals_t;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExecute,
    StMem,
    StWb
`ifdef ILLEGAL_TRAP_EN
    , StTrap
`endif
  } core_state_t;

  // ADDI x0, x0, 0
  localparam word NOP_INSTR        = 32'h0000_0013;
  localparam word DEFAULT_RESET_PC = 32'h0000_0000;
  localparam word DEFAULT_TRAP_VEC = 32'h0000_0100;

  // Redirect targets are forced word-aligned; the sequential path wraps mod 2^32.
  function automatic word next_seq_pc(word cur_pc, logic taken, logic [29:0] target_hi);
    return taken ? {target_hi, 2'b00} : cur_pc + 32'd4;
  endfunction

endpackage

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM: fetch, decode, execute, memory, writeback.
// Owns PC, instruction register and the execute-stage branch latch.
// Optional macro ILLEGAL_TRAP_EN: illegal instructions trap to TRAP_VEC instead of
// retiring as a NOP.
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter word RESET_PC = DEFAULT_RESET_PC,
  parameter word TRAP_VEC = DEFAULT_TRAP_VEC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  input  logic        dec_is_load,
  input  logic        dec_is_store,
  input  logic        dec_writes_rd,
  input  logic        dec_illegal,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic [31:0] pc,
  output logic        rf_we,
  output logic        retire
`ifdef ILLEGAL_TRAP_EN
  , output logic      trap
`endif
);

  core_state_t state_q;
  word         pc_q;
  word         instr_q;
  logic        taken_q;
  logic [29:0] target_hi_q;
  logic        mem_access;
  logic        unused_target_lsb;

  // An illegal word never touches data memory, even if decode flags a load/store.
  assign mem_access        = (dec_is_load | dec_is_store) & ~dec_illegal;
  assign unused_target_lsb = ^branch_target[1:0];

`ifndef ILLEGAL_TRAP_EN
  logic unused_trap_vec;
  assign unused_trap_vec = ^TRAP_VEC;
`endif

  // Single FSM: state, PC, IR and branch latch all advance here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      instr_q     <= NOP_INSTR;
      taken_q     <= 1'b0;
      target_hi_q <= '0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imem_ready) begin
            instr_q <= imem_rdata;
            state_q <= StDecode;
          end
        end
        StDecode: state_q <= StExecute;
        StExecute: begin
          taken_q     <= branch_taken;
          target_hi_q <= branch_target[31:2];
`ifdef ILLEGAL_TRAP_EN
          if (dec_illegal)     state_q <= StTrap;
          else if (mem_access) state_q <= StMem;
          else                 state_q <= StWb;
`else
          if (mem_access) state_q <= StMem;
          else            state_q <= StWb;
`endif
        end
        StMem: begin
          if (dmem_ready) state_q <= StWb;
        end
        StWb: begin
          pc_q    <= next_seq_pc(pc_q, taken_q, target_hi_q);
          state_q <= StFetch;
        end
`ifdef ILLEGAL_TRAP_EN
        StTrap: begin
          pc_q    <= TRAP_VEC;
          state_q <= StFetch;
        end
`endif
        default: state_q <= StFetch;
      endcase
    end
  end

  // Moore outputs decoded from the state register.
  assign imem_req  = (state_q == StFetch);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign dmem_req  = (state_q == StMem);
  assign dmem_we   = (state_q == StMem) & dec_is_store;
  assign retire    = (state_q == StWb);
  // Illegal words reaching WB (non-trap build) retire as NOPs.
  assign rf_we     = (state_q == StWb) & dec_writes_rd & ~dec_illegal;
`ifdef ILLEGAL_TRAP_EN
  assign trap      = (state_q == StTrap);
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: randomized instruction stream with random
// memory wait states, checked against an instruction-level reference model.
module tb_core_sequencer;
  import core_sequencer_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TVEC   = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic        dec_is_load, dec_is_store, dec_writes_rd, dec_illegal;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        dmem_req, dmem_we;
  logic        dmem_ready = 1'b0;
  logic [31:0] pc;
  logic        rf_we, retire;
  logic        trap_w;

  always #5 clk = ~clk;

  core_sequencer #(.RESET_PC(RST_PC), .TRAP_VEC(TVEC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .instr(instr),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
    .dec_writes_rd(dec_writes_rd), .dec_illegal(dec_illegal),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .pc(pc), .rf_we(rf_we), .retire(retire)
`ifdef ILLEGAL_TRAP_EN
    , .trap(trap_w)
`endif
  );

`ifndef ILLEGAL_TRAP_EN
  assign trap_w = 1'b0;
`endif

  // External decode block, driven from the DUT's instruction register.
  always_comb begin
    logic [6:0] op;
    op            = instr[6:0];
    dec_is_load   = (op == OPCODE_LOAD);
    dec_is_store  = (op == OPCODE_STORE);
    dec_writes_rd = (op == OPCODE_LOAD) || (op == OPCODE_OP_IMM) || (op == OPCODE_OP);
    dec_illegal   = !((op == OPCODE_LOAD) || (op == OPCODE_STORE) || (op == OPCODE_OP_IMM) ||
                      (op == OPCODE_OP) || (op == OPCODE_BRANCH));
  end

  typedef enum int {KAlu, KBranch, KLoad, KStore, KIllegal} kind_t;

  typedef struct {
    kind_t       kind;
    logic [31:0] word_v;
    logic        taken;
    logic [31:0] target;
    int          fwait;
    int          mwait;
  } stim_t;

  typedef struct {
    logic [31:0] pc_v;
    logic        is_trap;
    logic        rf_we_v;
    logic [31:0] next_pc;
    int          lat;
    int          mem_cycles;
    logic        mem_we;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_pc = RST_PC;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Instruction-level reference: what one instruction must do, by its class.
  function automatic exp_t predict(input stim_t s, input logic [31:0] cur_pc);
    exp_t e;
    int   mem;
    e.pc_v       = cur_pc;
    e.is_trap    = 1'b0;
    e.mem_we     = (s.kind == KStore);
    mem          = (s.kind == KLoad || s.kind == KStore) ? s.mwait + 1 : 0;
    e.mem_cycles = mem;
    e.rf_we_v    = (s.kind == KAlu || s.kind == KLoad);
    e.next_pc    = s.taken ? (s.target & 32'hFFFF_FFFC) : cur_pc + 32'd4;
    e.lat        = s.fwait + 4 + mem;
`ifdef ILLEGAL_TRAP_EN
    if (s.kind == KIllegal) begin
      e.is_trap = 1'b1;
      e.next_pc = TVEC;
      e.lat     = s.fwait + 4;
    end
`endif
    return e;
  endfunction

  // Monitor: pops an expectation at each retire/trap pulse.
  int          cyc = 0;
  int          mem_cnt = 0;
  logic        next_chk = 1'b0;
  logic [31:0] next_exp = 32'h0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      cyc      = 0;
      mem_cnt  = 0;
      next_chk = 1'b0;
    end else begin
      cyc++;
      if (next_chk) begin
        check("next_imem_addr", imem_addr, next_exp);
        check("next_pc", pc, next_exp);
        next_chk = 1'b0;
      end
      if (dmem_req) begin
        mem_cnt++;
        if (sb.size() > 0) check("dmem_we", {31'b0, dmem_we}, {31'b0, sb[0].mem_we});
      end
      if (rf_we && !retire) check("rf_we_outside_wb", {31'b0, rf_we}, 32'h0);
      if (retire || trap_w) begin
        if (sb.size() == 0) begin
          check("unexpected_retire", {30'b0, retire, trap_w}, 32'h0);
        end else begin
          e = sb.pop_front();
          check("retire_pc", pc, e.pc_v);
          check("retire_kind", {30'b0, retire, trap_w}, e.is_trap ? 32'h1 : 32'h2);
          check("rf_we", {31'b0, rf_we}, {31'b0, e.rf_we_v});
          check("latency", cyc, e.lat);
          check("dmem_cycles", mem_cnt, e.mem_cycles);
          next_exp = e.next_pc;
          next_chk = 1'b1;
        end
        cyc     = 0;
        mem_cnt = 0;
      end
    end
  end

  task automatic do_reset();
    #1 rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_pc = RST_PC;
    @(negedge clk);
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL timeout_%s actual=expired required=event", name);
    sb.delete();
    do_reset();
  endtask

  function automatic stim_t mk(input kind_t k, input logic taken, input logic [31:0] tgt,
                               input int fw, input int mw);
    stim_t       s;
    logic [31:0] r;
    r        = $urandom;
    s.kind   = k;
    s.taken  = taken;
    s.target = tgt;
    s.fwait  = fw;
    s.mwait  = mw;
    unique case (k)
      KAlu:     s.word_v = {r[31:7], OPCODE_OP_IMM};
      KBranch:  s.word_v = {r[31:7], OPCODE_BRANCH};
      KLoad:    s.word_v = {r[31:7], OPCODE_LOAD};
      KStore:   s.word_v = {r[31:7], OPCODE_STORE};
      default:  s.word_v = 32'h0000_0000;
    endcase
    return s;
  endfunction

  // Driver: plays imem/dmem and the execute-stage redirect for one instruction.
  task automatic run_instr(input stim_t s);
    exp_t e;
    int   n;
    e = predict(s, model_pc);
    sb.push_back(e);
    model_pc      = e.next_pc;
    branch_taken  = s.taken;
    branch_target = s.target;
    n = 0;
    while (!imem_req && n < 20) begin @(negedge clk); n++; end
    if (!imem_req) begin timeout("fetch"); return; end
    for (int i = 0; i < s.fwait; i++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      dmem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    dmem_ready = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = s.word_v;
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    check("instr", instr, s.word_v);
    if (e.mem_cycles > 0) begin
      n = 0;
      while (!dmem_req && n < 10) begin @(negedge clk); n++; end
      if (!dmem_req) begin timeout("dmem_req"); return; end
      repeat (s.mwait) @(negedge clk);
      dmem_ready = 1'b1;
      @(negedge clk);
      dmem_ready = 1'b0;
    end
    n = 0;
    while (!(retire || trap_w) && n < 20) begin @(negedge clk); n++; end
    if (!(retire || trap_w)) timeout("retire");
  endtask

  // Load whose data access is abandoned by a reset pulse mid-wait.
  task automatic reset_in_mem();
    stim_t s;
    int    n;
    s = mk(KLoad, 1'b0, 32'h0, 0, 0);
    n = 0;
    while (!imem_req && n < 20) begin @(negedge clk); n++; end
    imem_ready = 1'b1;
    imem_rdata = s.word_v;
    @(negedge clk);
    imem_ready = 1'b0;
    n = 0;
    while (!dmem_req && n < 10) begin @(negedge clk); n++; end
    check("mem_reached", {31'b0, dmem_req}, 32'h1);
    repeat (2) @(negedge clk);
    do_reset();
    check("rst_imem_addr", imem_addr, RST_PC);
    check("rst_instr", instr, NOP_INSTR);
    check("rst_imem_req", {31'b0, imem_req}, 32'h1);
  endtask

  initial begin
    stim_t s;
    kind_t k;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_imem_req", {31'b0, imem_req}, 32'h1);
    check("reset_imem_addr", imem_addr, RST_PC);
    check("reset_instr", instr, NOP_INSTR);
    check("reset_outputs", {28'b0, retire, rf_we, dmem_req, trap_w}, 32'h0);

    run_instr(mk(KAlu, 1'b0, 32'h0, 0, 0));              // pc 0x0
    run_instr(mk(KLoad, 1'b0, 32'h0, 0, 3));             // pc 0x4, 4 dmem cycles
    run_instr(mk(KStore, 1'b0, 32'h0, 1, 0));            // pc 0x8
    run_instr(mk(KAlu, 1'b0, 32'h0, 0, 0));              // pc 0xC
    run_instr(mk(KBranch, 1'b1, 32'h42, 0, 0));          // pc 0x10 -> 0x40
    run_instr(mk(KBranch, 1'b1, 32'hFFFF_FFFE, 0, 0));   // -> 0xFFFF_FFFC
    run_instr(mk(KAlu, 1'b0, 32'h0, 0, 0));              // wraps to 0
    run_instr(mk(KIllegal, 1'b0, 32'h0, 0, 0));
    run_instr(mk(KAlu, 1'b0, 32'h0, 2, 0));
    reset_in_mem();

    for (int i = 0; i < 80; i++) begin
      k = kind_t'($urandom_range(0, 4));
      s = mk(k, (k == KBranch) ? 1'($urandom_range(0, 1)) : 1'b0, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3));
      run_instr(s);
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
